// File: rtl/countdown_ctrl_pkg.sv
// Shared types and constants for the countdown controller.
// Holds the FSM state encoding, the two-digit BCD type and digit-select codes.
package countdown_ctrl_pkg;

  typedef enum logic [1:0] {
    SET,
    RUN,
    PAUSE,
    EXPIRED
  } state_t;

  typedef logic [7:0] bcd2_t;

  localparam logic SEL_ONES = 1'b0;
  localparam logic SEL_TENS = 1'b1;

  function automatic bcd2_t to_bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd2_updown.sv
// Two-digit BCD step-up/step-down with wrap between 0 and MAX_COUNT.
// Simultaneous inc and dec cancel out.
module bcd2_updown
  import countdown_ctrl_pkg::*;
#(
  parameter int MAX_COUNT = 99
) (
  input  bcd2_t value,
  input  logic  inc,
  input  logic  dec,
  output bcd2_t result
);

  localparam bcd2_t MAX_BCD = to_bcd2(MAX_COUNT);

  always_comb begin
    result = value;
    if (inc && !dec) begin
      if (value == MAX_BCD)
        result = '0;
      else if (value[3:0] == 4'd9)
        result = {value[7:4] + 4'd1, 4'd0};
      else
        result = {value[7:4], value[3:0] + 4'd1};
    end else if (dec && !inc) begin
      if (value == '0)
        result = MAX_BCD;
      else if (value[3:0] == 4'd0)
        result = {value[7:4] - 4'd1, 4'd9};
      else
        result = {value[7:4], value[3:0] - 4'd1};
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Encoder-set BCD countdown timer with run/pause/alarm FSM and digit mux.
// Define COUNTDOWN_CTRL_RELOAD_EN to restore the preset when the alarm ends.
module countdown_ctrl
  import countdown_ctrl_pkg::*;
#(
  parameter int MAX_COUNT   = 99,
  parameter int ALARM_TICKS = 5,
  parameter int REFRESH_DIV = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       enc_inc,
  input  logic       enc_dec,
  input  logic       start_btn,
  output logic [7:0] count_bcd,
  output logic       dis_sel,
  output logic [3:0] dis_bcd,
  output logic       running,
  output logic       alarm
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int AT_W  = $clog2(ALARM_TICKS + 1);

  state_t          state;
  state_t          state_d;
  bcd2_t           count_d;
  bcd2_t           ud_out;
  bcd2_t           restore;
  logic            ud_inc;
  logic            ud_dec;
  logic            enc_step;
  logic [AT_W-1:0] atick;
  logic [AT_W-1:0] atick_d;
  logic            btn_q;
  logic            armed;
  logic            start;
  logic [DIV_W-1:0] div;
  logic            div_last;
  logic            sel_d;

`ifdef COUNTDOWN_CTRL_RELOAD_EN
  bcd2_t preset;
  bcd2_t preset_d;
  assign restore = preset;
`else
  assign restore = '0;
`endif

  // armed blocks a start edge until the button has been seen low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q <= 1'b0;
      armed <= 1'b0;
      start <= 1'b0;
    end else begin
      btn_q <= start_btn;
      armed <= armed | ~start_btn;
      start <= start_btn & ~btn_q & armed;
    end
  end

  assign enc_step = enc_inc ^ enc_dec;

  always_comb begin
    ud_inc = 1'b0;
    ud_dec = 1'b0;
    case (state)
      SET, PAUSE: begin
        ud_inc = enc_inc;
        ud_dec = enc_dec;
      end
      RUN:     ud_dec = tick_1hz;
      default: ;
    endcase
  end

  bcd2_updown #(
    .MAX_COUNT(MAX_COUNT)
  ) u_step (
    .value (count_bcd),
    .inc   (ud_inc),
    .dec   (ud_dec),
    .result(ud_out)
  );

  always_comb begin
    state_d  = state;
    count_d  = count_bcd;
    atick_d  = atick;
`ifdef COUNTDOWN_CTRL_RELOAD_EN
    preset_d = preset;
`endif
    case (state)
      SET: begin
        if (start) begin
          if (count_bcd != '0) begin
            state_d  = RUN;
`ifdef COUNTDOWN_CTRL_RELOAD_EN
            preset_d = count_bcd;
`endif
          end
        end else if (enc_step) begin
          count_d = ud_out;
        end
      end
      RUN: begin
        if (start) begin
          state_d = PAUSE;
        end else if (tick_1hz) begin
          count_d = ud_out;
          if (count_bcd == 8'h01) begin
            state_d = EXPIRED;
            atick_d = '0;
          end
        end
      end
      PAUSE: begin
        if (start)
          state_d = (count_bcd != '0) ? RUN : SET;
        else if (enc_step)
          count_d = ud_out;
      end
      EXPIRED: begin
        count_d = '0;
        if (start) begin
          state_d = SET;
          count_d = restore;
        end else if (tick_1hz) begin
          if (atick == AT_W'(ALARM_TICKS - 1)) begin
            state_d = SET;
            count_d = restore;
          end else begin
            atick_d = atick + AT_W'(1);
          end
        end
      end
      default: state_d = SET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SET;
      count_bcd <= '0;
      atick     <= '0;
      running   <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      state     <= state_d;
      count_bcd <= count_d;
      atick     <= atick_d;
      running   <= (state_d == RUN);
      alarm     <= (state_d == EXPIRED);
    end
  end

`ifdef COUNTDOWN_CTRL_RELOAD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      preset <= '0;
    else
      preset <= preset_d;
  end
`endif

  assign div_last = (div == DIV_W'(REFRESH_DIV - 1));
  assign sel_d    = div_last ? ~dis_sel : dis_sel;

  // digit follows next count so dis_bcd always matches count_bcd
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div     <= '0;
      dis_sel <= SEL_ONES;
      dis_bcd <= '0;
    end else begin
      div     <= div_last ? '0 : div + DIV_W'(1);
      dis_sel <= sel_d;
      dis_bcd <= (sel_d == SEL_TENS) ? count_d[7:4] : count_d[3:0];
    end
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Scoreboard bench for countdown_ctrl: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_countdown_ctrl;

`ifdef COUNTDOWN_CTRL_RELOAD_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       enc_inc = 1'b0;
  logic       enc_dec = 1'b0;
  logic       start_btn = 1'b0;
  logic [7:0] count_bcd;
  logic       dis_sel;
  logic [3:0] dis_bcd;
  logic       running;
  logic       alarm;

  typedef struct {
    string      nm;
    logic [7:0] cnt;
    logic       run;
    logic       alm;
    logic       sel;
    logic [3:0] dig;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   n = 0;

  countdown_ctrl #(
    .MAX_COUNT  (99),
    .ALARM_TICKS(5),
    .REFRESH_DIV(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_1hz (tick_1hz),
    .enc_inc  (enc_inc),
    .enc_dec  (enc_dec),
    .start_btn(start_btn),
    .count_bcd(count_bcd),
    .dis_sel  (dis_sel),
    .dis_bcd  (dis_bcd),
    .running  (running),
    .alarm    (alarm)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] tobcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic cyc(input bit t, input bit i, input bit d, input bit b,
                     input logic [7:0] ec, input bit er, input bit ea,
                     input string nm);
    exp_t e;
    tick_1hz  = t;
    enc_inc   = i;
    enc_dec   = d;
    start_btn = b;
    @(posedge clk);
    #1;
    n++;
    e.nm  = nm;
    e.cnt = ec;
    e.run = er;
    e.alm = ea;
    e.sel = ((n / 4) % 2) == 1;
    e.dig = e.sel ? ec[7:4] : ec[3:0];
    q.push_back(e);
    tick_1hz = 1'b0;
    enc_inc  = 1'b0;
    enc_dec  = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset(input bit btn_hold);
    exp_t e;
    #2;
    rst       = 1'b1;
    tick_1hz  = 1'b0;
    enc_inc   = 1'b0;
    enc_dec   = 1'b0;
    start_btn = btn_hold;
    #1;
    e.nm  = "reset";
    e.cnt = 8'h00;
    e.run = 1'b0;
    e.alm = 1'b0;
    e.sel = 1'b0;
    e.dig = 4'h0;
    q.push_back(e);
    @(negedge clk);
    #1;
    rst = 1'b0;
    n   = 0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (count_bcd !== e.cnt || running !== e.run || alarm !== e.alm ||
            dis_sel !== e.sel || dis_bcd !== e.dig) begin
          failures++;
          $display("FAIL %s: got cnt=%h run=%b alm=%b sel=%b dig=%h want cnt=%h run=%b alm=%b sel=%b dig=%h",
                   e.nm, count_bcd, running, alarm, dis_sel, dis_bcd,
                   e.cnt, e.run, e.alm, e.sel, e.dig);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    logic [7:0] r;
    int v;

    // basic countdown 03 -> 00 then alarm timeout
    do_reset(1'b0);
    cyc(0, 0, 0, 0, 8'h00, 0, 0, "arm");
    cyc(0, 1, 0, 0, 8'h01, 0, 0, "inc1");
    cyc(0, 1, 0, 0, 8'h02, 0, 0, "inc2");
    cyc(0, 1, 0, 0, 8'h03, 0, 0, "inc3");
    cyc(0, 0, 0, 1, 8'h03, 0, 0, "start_lat");
    cyc(0, 0, 0, 1, 8'h03, 1, 0, "start_run");
    cyc(0, 0, 0, 0, 8'h03, 1, 0, "btn_rel");
    cyc(1, 0, 0, 0, 8'h02, 1, 0, "tick02");
    cyc(1, 0, 0, 0, 8'h01, 1, 0, "tick01");
    cyc(1, 0, 0, 0, 8'h00, 0, 1, "tick00_alarm");
    for (int k = 0; k < 4; k++)
      cyc(1, 0, 0, 0, 8'h00, 0, 1, "exp_hold");
    r = RELOAD ? 8'h03 : 8'h00;
    cyc(1, 0, 0, 0, r, 0, 0, "exp_timeout");

    // wrap and simultaneous encoder pulses, zero start ignored
    do_reset(1'b0);
    cyc(0, 0, 0, 0, 8'h00, 0, 0, "arm");
    cyc(0, 0, 1, 0, 8'h99, 0, 0, "dec_wrap");
    cyc(0, 1, 0, 0, 8'h00, 0, 0, "inc_wrap");
    cyc(0, 1, 1, 0, 8'h00, 0, 0, "inc_dec_both");
    cyc(0, 0, 0, 1, 8'h00, 0, 0, "zero_start_a");
    cyc(0, 0, 0, 1, 8'h00, 0, 0, "zero_start_b");
    cyc(0, 0, 0, 0, 8'h00, 0, 0, "zero_start_c");

    // pause behaviour
    for (int i = 1; i <= 10; i++)
      cyc(0, 1, 0, 0, tobcd(i), 0, 0, "inc_to10");
    cyc(0, 0, 0, 1, 8'h10, 0, 0, "start_lat");
    cyc(0, 0, 0, 1, 8'h10, 1, 0, "start_run");
    cyc(0, 0, 0, 0, 8'h10, 1, 0, "btn_rel");
    cyc(1, 0, 0, 0, 8'h09, 1, 0, "borrow09");
    cyc(0, 0, 0, 1, 8'h09, 1, 0, "pause_lat");
    cyc(1, 0, 0, 1, 8'h09, 0, 0, "start_beats_tick");
    cyc(1, 0, 0, 0, 8'h09, 0, 0, "pause_tick_ign");
    cyc(0, 0, 1, 0, 8'h08, 0, 0, "pause_dec");
    cyc(0, 0, 0, 1, 8'h08, 0, 0, "resume_lat");
    cyc(0, 0, 0, 1, 8'h08, 1, 0, "resume_run");
    cyc(0, 0, 0, 0, 8'h08, 1, 0, "btn_rel");
    cyc(1, 0, 0, 0, 8'h07, 1, 0, "run_tick07");
    cyc(0, 1, 0, 0, 8'h07, 1, 0, "run_enc_ign");

    // expiry from 02, then start aborts the alarm
    do_reset(1'b0);
    cyc(0, 0, 0, 0, 8'h00, 0, 0, "arm");
    cyc(0, 1, 0, 0, 8'h01, 0, 0, "inc1");
    cyc(0, 1, 0, 0, 8'h02, 0, 0, "inc2");
    cyc(0, 0, 0, 1, 8'h02, 0, 0, "start_lat");
    cyc(0, 0, 0, 1, 8'h02, 1, 0, "start_run");
    cyc(0, 0, 0, 0, 8'h02, 1, 0, "btn_rel");
    cyc(1, 0, 0, 0, 8'h01, 1, 0, "tick01");
    cyc(1, 0, 0, 0, 8'h00, 0, 1, "tick00_alarm");
    for (int k = 0; k < 4; k++)
      cyc(1, 0, 0, 0, 8'h00, 0, 1, "exp_hold");
    r = RELOAD ? 8'h02 : 8'h00;
    cyc(1, 0, 0, 0, r, 0, 0, "reload02");
    v = RELOAD ? 3 : 1;
    cyc(0, 1, 0, 0, tobcd(v), 0, 0, "inc_again");
    cyc(0, 0, 0, 1, tobcd(v), 0, 0, "start_lat");
    cyc(0, 0, 0, 1, tobcd(v), 1, 0, "start_run");
    cyc(0, 0, 0, 0, tobcd(v), 1, 0, "btn_rel");
    for (int k = v - 1; k >= 0; k--)
      cyc(1, 0, 0, 0, tobcd(k), k != 0, k == 0, "run_down");
    cyc(0, 0, 0, 1, 8'h00, 0, 1, "exp_start_lat");
    cyc(0, 0, 0, 1, tobcd(RELOAD ? v : 0), 0, 0, "exp_start_set");
    cyc(0, 0, 0, 0, tobcd(RELOAD ? v : 0), 0, 0, "btn_rel");

    // start held high through reset must not count as an edge
    do_reset(1'b1);
    cyc(0, 1, 0, 1, 8'h01, 0, 0, "held_inc");
    cyc(0, 0, 0, 1, 8'h01, 0, 0, "held_no_start_a");
    cyc(0, 0, 0, 1, 8'h01, 0, 0, "held_no_start_b");
    cyc(0, 0, 0, 0, 8'h01, 0, 0, "held_release");
    cyc(0, 0, 0, 1, 8'h01, 0, 0, "fresh_lat");
    cyc(0, 0, 0, 1, 8'h01, 1, 0, "fresh_run");

    // reset in the middle of a run
    do_reset(1'b0);
    cyc(0, 0, 0, 0, 8'h00, 0, 0, "arm");
    for (int i = 1; i <= 5; i++)
      cyc(0, 1, 0, 0, tobcd(i), 0, 0, "inc_to05");
    cyc(0, 0, 0, 1, 8'h05, 0, 0, "start_lat");
    cyc(0, 0, 0, 1, 8'h05, 1, 0, "start_run");
    cyc(0, 0, 0, 0, 8'h05, 1, 0, "btn_rel");
    do_reset(1'b0);
    for (int k = 0; k < 3; k++)
      cyc(1, 0, 0, 0, 8'h00, 0, 0, "post_rst_tick");

    // display mux at count 47
    do_reset(1'b0);
    for (int i = 1; i <= 47; i++)
      cyc(0, 1, 0, 0, tobcd(i), 0, 0, "inc_to47");
    for (int k = 0; k < 12; k++)
      cyc(0, 0, 0, 0, 8'h47, 0, 0, "disp47");

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
